kbd_move_entry: RTL and testbench

// - Consumes the 3-byte keystroke frames (make, F0, make) from the PS/2 keyboard receiver.
// - Assembles a chess move typed as <file><rank><file><rank><Enter>, e.g. "E2E4<Enter>".
// - Presents the move to the engine core as from/to squares with a valid/ack handshake.
// - Sits between the keyboard receiver and the move-validation / engine logic.

---
 rtl/kbd_move_entry.sv | 178 +++++++++++++++++
 tb/tb_kbd_move_entry.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/kbd_move_entry.sv
// Chess move entry from PS/2 keystroke frames: assembles <file><rank><file><rank><Enter>
// into from/to squares and hands them to the engine with a valid/ack handshake.
module kbd_move_entry #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] KEY_ENTER   = 8'h5A,
    parameter logic [7:0] KEY_BKSP    = 8'h66,
    parameter logic [7:0] KEY_ESC     = 8'h76
) (
    input  logic       clk50,
    input  logic       reset_n,
    input  logic       scan_ready,
    input  logic [7:0] scan_code1,
    input  logic [7:0] scan_code2,
    input  logic [7:0] scan_code3,
    input  logic       move_ack,
    output logic [5:0] from_sq,
    output logic [5:0] to_sq,
    output logic       move_valid,
    output logic [2:0] entry_state,
    output logic       key_err
);

    typedef enum logic [2:0] {
        S_FROM_FILE = 3'd0,
        S_FROM_RANK = 3'd1,
        S_TO_FILE   = 3'd2,
        S_TO_RANK   = 3'd3,
        S_CONFIRM   = 3'd4,
        S_HOLD      = 3'd5
    } state_t;

    // {hit, index}
    function automatic logic [3:0] decode_file(input logic [7:0] c);
        case (c)
            8'h1C: decode_file = 4'b1_000;
            8'h32: decode_file = 4'b1_001;
            8'h21: decode_file = 4'b1_010;
            8'h23: decode_file = 4'b1_011;
            8'h24: decode_file = 4'b1_100;
            8'h2B: decode_file = 4'b1_101;
            8'h34: decode_file = 4'b1_110;
            8'h33: decode_file = 4'b1_111;
            default: decode_file = 4'b0_000;
        endcase
    endfunction

    function automatic logic [3:0] decode_rank(input logic [7:0] c);
        case (c)
            8'h16: decode_rank = 4'b1_000;
            8'h1E: decode_rank = 4'b1_001;
            8'h26: decode_rank = 4'b1_010;
            8'h25: decode_rank = 4'b1_011;
            8'h2E: decode_rank = 4'b1_100;
            8'h36: decode_rank = 4'b1_101;
            8'h3D: decode_rank = 4'b1_110;
            8'h3E: decode_rank = 4'b1_111;
            default: decode_rank = 4'b0_000;
        endcase
    endfunction

    function automatic logic frame_ok(input logic [7:0] c1, input logic [7:0] c2,
                                      input logic [7:0] c3);
        frame_ok = (c2 == 8'hF0) && (c1 == c3);
    endfunction

    // Stage p0: synchronise scan_ready; the event is its rising edge inside the chain
    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   rise_p0;
    assign rise_p0 = sync_p0[SYNC_STAGES-2] & ~sync_p0[SYNC_STAGES-1];

    // Stage p1: frame captured on the synchronised edge
    logic       vld_p1;
    logic [7:0] code1_p1, code2_p1, code3_p1;

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], scan_ready};
            vld_p1  <= rise_p0;
        end
    end

    always_ff @(posedge clk50) begin
        if (rise_p0) begin
            code1_p1 <= scan_code1;
            code2_p1 <= scan_code2;
            code3_p1 <= scan_code3;
        end
    end

    // Stage p2: entry FSM and registered outputs
    state_t     state_p2, nxt_state;
    logic [5:0] nxt_from, nxt_to;
    logic       nxt_valid, nxt_err;
    logic [3:0] file_dec, rank_dec;

    assign file_dec = decode_file(code1_p1);
    assign rank_dec = decode_rank(code1_p1);

    always_comb begin
        nxt_state = state_p2;
        nxt_from  = from_sq;
        nxt_to    = to_sq;
        nxt_valid = move_valid;
        nxt_err   = 1'b0;
        if (state_p2 == S_HOLD) begin
            // Keys are dropped in HOLD; ack alone decides the exit
            if (move_ack) begin
                nxt_valid = 1'b0;
                nxt_from  = '0;
                nxt_to    = '0;
                nxt_state = S_FROM_FILE;
            end
        end else if (vld_p1) begin
            if (!frame_ok(code1_p1, code2_p1, code3_p1)) begin
                nxt_err = 1'b1;
            end else if (code1_p1 == KEY_ESC) begin
                nxt_from  = '0;
                nxt_to    = '0;
                nxt_state = S_FROM_FILE;
            end else if (code1_p1 == KEY_BKSP) begin
                case (state_p2)
                    S_FROM_RANK: begin nxt_from[2:0] = '0; nxt_state = S_FROM_FILE; end
                    S_TO_FILE:   begin nxt_from[5:3] = '0; nxt_state = S_FROM_RANK; end
                    S_TO_RANK:   begin nxt_to[2:0]   = '0; nxt_state = S_TO_FILE;   end
                    S_CONFIRM:   begin nxt_to[5:3]   = '0; nxt_state = S_TO_RANK;   end
                    default: ;
                endcase
            end else if (code1_p1 == KEY_ENTER) begin
                if (state_p2 == S_CONFIRM && from_sq != to_sq) begin
                    nxt_valid = 1'b1;
                    nxt_state = S_HOLD;
                end else if (state_p2 == S_CONFIRM) begin
                    nxt_err   = 1'b1;
                    nxt_to    = '0;
                    nxt_state = S_TO_FILE;
                end else begin
                    nxt_err = 1'b1;
                end
            end else if (file_dec[3] && state_p2 == S_FROM_FILE) begin
                nxt_from[2:0] = file_dec[2:0];
                nxt_state     = S_FROM_RANK;
            end else if (rank_dec[3] && state_p2 == S_FROM_RANK) begin
                nxt_from[5:3] = rank_dec[2:0];
                nxt_state     = S_TO_FILE;
            end else if (file_dec[3] && state_p2 == S_TO_FILE) begin
                nxt_to[2:0] = file_dec[2:0];
                nxt_state   = S_TO_RANK;
            end else if (rank_dec[3] && state_p2 == S_TO_RANK) begin
                nxt_to[5:3] = rank_dec[2:0];
                nxt_state   = S_CONFIRM;
            end else begin
                nxt_err = 1'b1;
            end
        end
    end

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            state_p2   <= S_FROM_FILE;
            from_sq    <= '0;
            to_sq      <= '0;
            move_valid <= 1'b0;
            key_err    <= 1'b0;
        end else begin
            state_p2   <= nxt_state;
            from_sq    <= nxt_from;
            to_sq      <= nxt_to;
            move_valid <= nxt_valid;
            key_err    <= nxt_err;
        end
    end

    assign entry_state = state_p2;

endmodule

// File: tb/tb_kbd_move_entry.sv
// Scoreboard bench for kbd_move_entry: each key frame pushes its expected outcome,
// which is popped when the frame reaches the FSM three clocks after scan_ready rises.
module tb_kbd_move_entry;

    logic       clk50 = 1'b0;
    logic       reset_n = 1'b0;
    logic       scan_ready = 1'b0;
    logic [7:0] scan_code1 = 8'h00;
    logic [7:0] scan_code2 = 8'h00;
    logic [7:0] scan_code3 = 8'h00;
    logic       move_ack = 1'b0;
    logic [5:0] from_sq, to_sq;
    logic       move_valid, key_err;
    logic [2:0] entry_state;

    kbd_move_entry dut (
        .clk50(clk50), .reset_n(reset_n), .scan_ready(scan_ready),
        .scan_code1(scan_code1), .scan_code2(scan_code2), .scan_code3(scan_code3),
        .move_ack(move_ack), .from_sq(from_sq), .to_sq(to_sq),
        .move_valid(move_valid), .entry_state(entry_state), .key_err(key_err)
    );

    always #10 clk50 = ~clk50;

    typedef struct {
        int st;
        int frm;
        int to;
        int vld;
        int err;
    } exp_t;

    exp_t sb[$];
    exp_t e_m;
    int   checks = 0;
    int   errors = 0;
    int   err_cycles = 0;
    int   exp_err_total = 0;
    logic sr_last = 1'b0;
    logic [2:0] tb_pipe = 3'b000;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Key event latency: scan_ready seen at posedge k acts on posedge k+2
    always @(posedge clk50) begin
        tb_pipe <= {tb_pipe[1:0], scan_ready & ~sr_last};
        sr_last <= scan_ready;
    end

    always @(negedge clk50) begin
        if (key_err) err_cycles++;
        if (tb_pipe[2]) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                e_m = sb.pop_front();
                check("state", int'(entry_state), e_m.st);
                check("from_sq", int'(from_sq), e_m.frm);
                check("to_sq", int'(to_sq), e_m.to);
                check("move_valid", int'(move_valid), e_m.vld);
                check("key_err", int'(key_err), e_m.err);
            end
        end
    end

    task automatic send(input logic [7:0] c1, input logic [7:0] c2, input logic [7:0] c3,
                        input int st, input int frm, input int to, input int vld,
                        input int err, input bit ack = 1'b0, input int hold = 3);
        exp_t e;
        e.st = st; e.frm = frm; e.to = to; e.vld = vld; e.err = err;
        sb.push_back(e);
        exp_err_total += err;
        @(negedge clk50);
        scan_code1 = c1; scan_code2 = c2; scan_code3 = c3;
        scan_ready = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk50);
            if (i == 1 && ack) move_ack = 1'b1;
            if (i == 2) move_ack = 1'b0;
        end
        scan_ready = 1'b0;
        repeat (3) @(negedge clk50);
    endtask

    task automatic key(input logic [7:0] c, input int st, input int frm, input int to,
                       input int vld, input int err);
        send(c, 8'hF0, c, st, frm, to, vld, err);
    endtask

    task automatic ack_pulse();
        @(negedge clk50);
        move_ack = 1'b1;
        @(negedge clk50);
        move_ack = 1'b0;
        check("ack_state", int'(entry_state), 0);
        check("ack_valid", int'(move_valid), 0);
        check("ack_from", int'(from_sq), 0);
        check("ack_to", int'(to_sq), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk50);
        check("rst_state", int'(entry_state), 0);
        check("rst_valid", int'(move_valid), 0);
        check("rst_from", int'(from_sq), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk50);

        // E2E4 Enter
        key(8'h24, 1, 4, 0, 0, 0);
        key(8'h1E, 2, 12, 0, 0, 0);
        key(8'h24, 3, 12, 4, 0, 0);
        key(8'h25, 4, 12, 28, 0, 0);
        key(8'h5A, 5, 12, 28, 1, 0);
        ack_pulse();

        // A1, BKSP, 3, H8, Enter
        key(8'h1C, 1, 0, 0, 0, 0);
        key(8'h16, 2, 0, 0, 0, 0);
        key(8'h66, 1, 0, 0, 0, 0);
        key(8'h26, 2, 16, 0, 0, 0);
        key(8'h33, 3, 16, 7, 0, 0);
        key(8'h3E, 4, 16, 63, 0, 0);
        key(8'h5A, 5, 16, 63, 1, 0);
        ack_pulse();

        // Malformed frames leave entry untouched; ESC clears; BKSP at 0 is silent
        key(8'h32, 1, 1, 0, 0, 0);
        send(8'h24, 8'hE0, 8'h24, 1, 1, 0, 0, 1);
        send(8'h24, 8'hF0, 8'h2D, 1, 1, 0, 0, 1);
        key(8'h76, 0, 0, 0, 0, 0);
        key(8'h66, 0, 0, 0, 0, 0);
        key(8'h5A, 0, 0, 0, 0, 1);

        // Wrong class, then identical squares rejected at Enter
        key(8'h2E, 0, 0, 0, 0, 1);
        key(8'h34, 1, 6, 0, 0, 0);
        key(8'h16, 2, 6, 0, 0, 0);
        key(8'h34, 3, 6, 6, 0, 0);
        key(8'h16, 4, 6, 6, 0, 0);
        key(8'h1C, 4, 6, 6, 0, 1);
        key(8'h5A, 2, 6, 0, 0, 1);
        key(8'h76, 0, 0, 0, 0, 0);

        // HOLD: keys dropped, ack wins over a coincident key
        key(8'h1C, 1, 0, 0, 0, 0);
        key(8'h16, 2, 0, 0, 0, 0);
        key(8'h32, 3, 0, 1, 0, 0);
        key(8'h16, 4, 0, 1, 0, 0);
        key(8'h5A, 5, 0, 1, 1, 0);
        key(8'h21, 5, 0, 1, 1, 0);
        send(8'h21, 8'hF0, 8'h21, 0, 0, 0, 0, 0, 1'b1);

        // Async reset in S_TO_RANK
        key(8'h23, 1, 3, 0, 0, 0);
        key(8'h25, 2, 27, 0, 0, 0);
        key(8'h23, 3, 27, 3, 0, 0);
        @(negedge clk50);
        #3 reset_n = 1'b0;
        #1;
        check("async_state", int'(entry_state), 0);
        check("async_from", int'(from_sq), 0);
        check("async_to", int'(to_sq), 0);
        check("async_valid", int'(move_valid), 0);
        @(negedge clk50);
        reset_n = 1'b1;
        @(negedge clk50);

        // scan_ready held high: one event only
        send(8'h21, 8'hF0, 8'h21, 1, 2, 0, 0, 0, 1'b0, 1000);
        check("hold_state", int'(entry_state), 1);
        check("hold_from", int'(from_sq), 2);

        repeat (5) @(negedge clk50);
        check("sb_drain", sb.size(), 0);
        check("err_cycles", err_cycles, exp_err_total);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
